// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the program counter, presents it to instruction memory and captures
// the returned instruction into the IF/ID register. Execute can redirect the
// PC; a redirect flushes the instruction fetched in the same cycle. A redirect
// to a non word-aligned target is fatal: it is recorded and the stage halts
// until reset.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   PCSrc       redirect request from execute
//   PCTarget    redirect address, valid when PCSrc=1
//   StallF      hazard-unit stall, holds PCF and IF/ID
//   PCF         current fetch address to instruction memory
//   InstrF      instruction memory read data for PCF (same cycle)
//   InstrD      IF/ID instruction
//   PCD         IF/ID instruction address
//   PCPlus4D    IF/ID instruction address + 4
//   ValidD      IF/ID holds a real, non-flushed instruction
//   MisalignErr sticky misaligned-redirect flag
//   MisalignPC  offending redirect target
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    input  logic                  StallF,
    output logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  MisalignErr,
    output logic [DATA_WIDTH-1:0] MisalignPC
);

    // addi x0, x0, 0 -- the bubble placed in IF/ID on flush and reset
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] instr_nxt;
    logic [DATA_WIDTH-1:0] pcd_nxt;
    logic [DATA_WIDTH-1:0] pcplus4_nxt;
    logic                  valid_nxt;
    logic                  err_nxt;
    logic [DATA_WIDTH-1:0] errpc_nxt;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  misaligned;

    // Wraps modulo 2^DATA_WIDTH by construction
    assign pc_plus4   = PCF + DATA_WIDTH'(4);
    assign misaligned = (PCTarget[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-register values. A redirect outranks a stall; in
    // BOOT the stall is ignored and the PC is not advanced, so the reset
    // address is captured into IF/ID while PCF stays put for one more cycle.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = PCF;
        instr_nxt   = InstrD;
        pcd_nxt     = PCD;
        pcplus4_nxt = PCPlus4D;
        valid_nxt   = ValidD;
        err_nxt     = MisalignErr;
        errpc_nxt   = MisalignPC;

        case (state)
            BOOT, RUN: begin
                if (PCSrc) begin
                    instr_nxt   = NOP;
                    pcd_nxt     = '0;
                    pcplus4_nxt = '0;
                    valid_nxt   = 1'b0;
                    if (misaligned) begin
                        err_nxt   = 1'b1;
                        errpc_nxt = PCTarget;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = PCTarget;
                        state_nxt = RUN;
                    end
                end else if (state == BOOT || !StallF) begin
                    instr_nxt   = InstrF;
                    pcd_nxt     = PCF;
                    pcplus4_nxt = pc_plus4;
                    valid_nxt   = 1'b1;
                    state_nxt   = RUN;
                    if (state == RUN) begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCF         <= RESET_PC;
            InstrD      <= NOP;
            PCD         <= '0;
            PCPlus4D    <= '0;
            ValidD      <= 1'b0;
            MisalignErr <= 1'b0;
            MisalignPC  <= '0;
        end else begin
            PCF         <= pc_nxt;
            InstrD      <= instr_nxt;
            PCD         <= pcd_nxt;
            PCPlus4D    <= pcplus4_nxt;
            ValidD      <= valid_nxt;
            MisalignErr <= err_nxt;
            MisalignPC  <= errpc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- scoreboard bench for fetch_stage.
//
// A stimulus process drives inputs on the falling edge, advances a reference
// model of the fetch stage and pushes the expected post-edge outputs into a
// queue. A monitor pops one entry after each rising edge and compares. A
// second instance with RESET_PC = FFFF_FFFC checks PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        StallF;
    logic [31:0] PCF, InstrF, InstrD, PCD, PCPlus4D, MisalignPC;
    logic        ValidD, MisalignErr;

    logic [31:0] w_pcf, w_instrf, w_instrd, w_pcd, w_pcplus4d, w_misalignpc;
    logic        w_validd, w_misalignerr;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcplus4;
        logic        valid;
        logic        err;
        logic [31:0] errpc;
    } exp_t;

    exp_t expq[$];

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: mode 0 = just out of reset, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pcd, m_pcplus4, m_errpc;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed scramble of the address
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign InstrF   = imem(PCF);
    assign w_instrf = imem(w_pcf);

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .StallF(StallF), .PCF(PCF), .InstrF(InstrF), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .MisalignErr(MisalignErr), .MisalignPC(MisalignPC)
    );

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .StallF(StallF), .PCF(w_pcf), .InstrF(w_instrf), .InstrD(w_instrd),
        .PCD(w_pcd), .PCPlus4D(w_pcplus4d), .ValidD(w_validd),
        .MisalignErr(w_misalignerr), .MisalignPC(w_misalignpc)
    );

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_pc      = 32'h0000_0000;
        m_instr   = NOP;
        m_pcd     = '0;
        m_pcplus4 = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_errpc   = '0;
    endtask

    task automatic model_flush();
        m_instr   = NOP;
        m_pcd     = '0;
        m_pcplus4 = '0;
        m_valid   = 1'b0;
    endtask

    task automatic model_fetch();
        m_instr   = imem(m_pc);
        m_pcd     = m_pc;
        m_pcplus4 = m_pc + 32'd4;
        m_valid   = 1'b1;
    endtask

    // Called on a falling edge; returns on the next falling edge
    task automatic applyStimulus(input logic src, input logic [31:0] tgt,
                                 input logic stall);
        exp_t e;
        PCSrc    = src;
        PCTarget = tgt;
        StallF   = stall;
        if (m_mode != 2) begin
            if (src) begin
                model_flush();
                if (tgt[1:0] != 2'b00) begin
                    m_err   = 1'b1;
                    m_errpc = tgt;
                    m_mode  = 2;
                end else begin
                    m_pc   = tgt;
                    m_mode = 1;
                end
            end else if (m_mode == 0) begin
                model_fetch();
                m_mode = 1;
            end else if (!stall) begin
                model_fetch();
                m_pc = m_pc + 32'd4;
            end
        end
        e.pcf     = m_pc;
        e.instr   = m_instr;
        e.pcd     = m_pcd;
        e.pcplus4 = m_pcplus4;
        e.valid   = m_valid;
        e.err     = m_err;
        e.errpc   = m_errpc;
        expq.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous assertion mid-cycle, release on a falling edge
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_pcf",      PCF,                 32'h0);
        checkOutput("rst_instrd",   InstrD,              NOP);
        checkOutput("rst_pcd",      PCD,                 32'h0);
        checkOutput("rst_pcplus4d", PCPlus4D,            32'h0);
        checkOutput("rst_validd",   {31'b0, ValidD},     32'h0);
        checkOutput("rst_err",      {31'b0, MisalignErr}, 32'h0);
        checkOutput("rst_errpc",    MisalignPC,          32'h0);
        checkOutput("rst_wrap_pcf", w_pcf,               32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare one scoreboard entry after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("pcf",      PCF,                  e.pcf);
                checkOutput("instrd",   InstrD,               e.instr);
                checkOutput("pcd",      PCD,                  e.pcd);
                checkOutput("pcplus4d", PCPlus4D,             e.pcplus4);
                checkOutput("validd",   {31'b0, ValidD},      {31'b0, e.valid});
                checkOutput("err",      {31'b0, MisalignErr}, {31'b0, e.err});
                checkOutput("errpc",    MisalignPC,           e.errpc);
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        logic        src, stall;
        rst_n    = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = '0;
        StallF   = 1'b0;
        model_reset();
        @(negedge clk);
        $display("[TB] reset and free run");
        doReset();

        // Free run from reset, also watching the wrapping instance
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrap_pcf_e1", w_pcf, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrap_pcf_e2", w_pcf, 32'h0000_0000);
        checkOutput("wrap_err",    {31'b0, w_misalignerr}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrap_pcf_e3", w_pcf, 32'h0000_0004);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("[TB] redirect from 0x10 to 0x40");
        checkOutput("pcf_before_redirect", PCF, 32'h10);
        applyStimulus(1'b1, 32'h40, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("[TB] stall at 0x20");
        applyStimulus(1'b1, 32'h1C, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("[TB] stall and redirect together");
        applyStimulus(1'b1, 32'h80, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("[TB] randomized run");
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) begin
                doReset();
            end
            src   = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            tgt   = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
            applyStimulus(src, tgt, stall);
        end

        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h42, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tgt = $urandom();
            applyStimulus(1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)));
        end
        checkOutput("halt_errpc", MisalignPC, 32'h42);
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);

        checkOutput("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
